dmem_port_arb: RTL
==================

# dmem_port_arb

- Arbitrates one shared DMem access port among NUM_REQ requesters: the router port, the upper TPU LdSt port and the lower TPU LdSt port.
- Grants are round-robin and burst-locked: a winner keeps the port until its burst length is consumed or it releases early.
- One instance sits in front of every DMem bank in the TPU array, between the requesters' LdSt/Rt request lines and the bank's Ready/Grant outputs.

## Interface
- NUM_REQ, 3, number of requesters; index 0 is the router port
- LEN_W, 4, burst-length width; maximum burst is 2^LEN_W-1 beats
- SEL_W, $clog2(NUM_REQ), width of the selected-index output
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- I_Req  in  NUM_REQ  request vector; bit i is requester i
- I_Len  in  NUM_REQ×LEN_W  burst length per requester; 0 is treated as 1
- I_Rls  in  NUM_REQ  early release from the current owner; other bits are ignored
- I_Mem_Ready  in  1  bank accepts a beat this cycle
- O_Grant  out  NUM_REQ  one-hot owner, registered
- O_Sel  out  SEL_W  binary index of the owner
- O_Valid  out  1  port owned; a beat transfers when O_Valid & I_Mem_Ready
- O_Last  out  1  the current beat is the final beat of the burst
- O_Busy  out  1  state ≠ IDLE

## Operation
- FSM states:
  - IDLE: arbitrate. Any I_Req set → BURST; otherwise stay.
  - BURST: the owner transfers beats. An accepted beat with beat count = len, or I_Rls[owner], → TURN.
  - TURN: one bubble cycle with O_Grant = 0. Arbitrate; a request → BURST, none → IDLE.
- Arbitration (IDLE and TURN only):
  - Winner is the first set I_Req bit at or above rr_ptr, wrapping at NUM_REQ.
  - On a grant, rr_ptr = winner+1, mod NUM_REQ.
  - The winner's I_Len is latched; 0 becomes 1.
- Beat counter:
  - LEN_W bits, cleared on grant.
  - Increments on each O_Valid & I_Mem_Ready.
  - O_Last = O_Valid & (count == len-1).
- Burst lock:
  - An owner dropping I_Req mid-burst has no effect.
  - Requests from non-owners are held off until TURN.
- Simultaneous events:
  - I_Rls[owner] and an accepted beat in the same cycle: the beat counts and the burst ends.
  - I_Rls with I_Mem_Ready = 0: the burst ends with no beat.
- A requester that is granted has its I_Req bit excluded from no later decision. It may win again at the next TURN if the other requesters are idle.

## Timing
- Reset values:
  - O_Grant = 0, O_Sel = 0, O_Valid = 0, O_Last = 0, O_Busy = 0.
  - State = IDLE, rr_ptr = 0, beat count = 0, latched len = 0.
- Reset asserted mid-burst aborts immediately. There is no completion of pending beats.
- Request latency: I_Req sampled in IDLE at cycle t → O_Grant and O_Valid high at t+1.
- Release: final beat accepted at cycle n → O_Valid = 0 at n+1 (TURN) → next owner granted at n+2. This is exactly one bubble between back-to-back bursts.
- O_Sel, O_Grant and O_Valid change only on clock edges; O_Last is combinational from registered state.
- Stall: I_Mem_Ready low holds the count indefinitely. There is no timeout.

## Configuration
- DMEM_ARB_ROUTER_PRIO_EN defined: requester 0 (router) wins whenever I_Req[0] is set at an arbitration point, ahead of round-robin.
  - rr_ptr is not updated on router grants.
  - A router grant still waits for the current burst to end; there is no preemption.
- Not defined: pure round-robin across all requesters.

## Structure
- Shared package pkg_tpu:
  - enum arb_state_t {ARB_IDLE, ARB_BURST, ARB_TURN}
  - constant DMEM_ARB_LEN_W = 4
- One sub-module, rr_pick:
  - Combinational find-first-set from a rotating pointer.
  - Inputs: request vector and pointer. Outputs: one-hot winner, binary index, found flag.

## Test plan
- Single requester: I_Req = 3'b010, I_Len[1] = 3, I_Mem_Ready = 1 → O_Grant = 3'b010 for cycles 1–3; O_Last on cycle 3; O_Grant = 0 on cycle 4 (TURN); then IDLE.
- Contention: all three request constantly, each with len 2 → grant order 0, 1, 2, 0 with one bubble between bursts; each burst lasts 2 cycles.
- Stalls: owner len 4, I_Mem_Ready toggles 1,0,0,1,1,0,1 → O_Last on the 7th cycle; grant held throughout.
- Early release: len 5, I_Rls asserted together with the 2nd accepted beat → TURN next cycle; the other waiting requester is granted one cycle later.
- Macro on: requester 1 owns the port, requesters 0 and 2 are pending → requester 0 is granted after TURN; rr_ptr is unchanged, so 2 wins next. Macro off: 2 wins first.
- Reset pulse during beat 2 of 4 → all outputs 0 in the same cycle; after reset release, a pending I_Req[2] is granted one cycle later with rr_ptr = 0.

Source files
------------

// File: rtl/pkg_tpu.sv
// Shared TPU definitions: DMem arbiter state encoding and default burst-length width.
package pkg_tpu;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BURST = 2'd1,
        ARB_TURN  = 2'd2
    } arb_state_t;

    localparam int DMEM_ARB_LEN_W = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational find-first-set starting at a rotating pointer, wrapping at N.
module rr_pick #(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_oh,
    output logic [IW-1:0] o_idx,
    output logic          o_found
);

    int w_best;

    // Pick the requester with the smallest rotated distance from the pointer.
    always_comb begin
        o_oh    = '0;
        o_idx   = '0;
        o_found = 1'b0;
        w_best  = N;
        for (int j = 0; j < N; j++) begin
            if (i_req[j] && (((j + N - int'(i_ptr)) % N) < w_best)) begin
                w_best  = (j + N - int'(i_ptr)) % N;
                o_oh    = '0;
                o_oh[j] = 1'b1;
                o_idx   = IW'(j);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_port_arb.sv
// Round-robin, burst-locked arbiter for one DMem bank port (router + two TPU LdSt ports).
// Define DMEM_ARB_ROUTER_PRIO_EN to let requester 0 (router) win every arbitration it requests.
module dmem_port_arb
    import pkg_tpu::*;
#(
    parameter int NUM_REQ = 3,
    parameter int LEN_W   = DMEM_ARB_LEN_W,
    parameter int SEL_W   = $clog2(NUM_REQ)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       I_Req,
    input  logic [NUM_REQ*LEN_W-1:0] I_Len,
    input  logic [NUM_REQ-1:0]       I_Rls,
    input  logic                     I_Mem_Ready,
    output logic [NUM_REQ-1:0]       O_Grant,
    output logic [SEL_W-1:0]         O_Sel,
    output logic                     O_Valid,
    output logic                     O_Last,
    output logic                     O_Busy
);

    arb_state_t         r_state;
    logic [SEL_W-1:0]   r_ptr;
    logic [SEL_W-1:0]   r_sel;
    logic [NUM_REQ-1:0] r_grant;
    logic [LEN_W-1:0]   r_cnt;
    logic [LEN_W-1:0]   r_len;

    logic [NUM_REQ-1:0] w_pick_oh;
    logic [SEL_W-1:0]   w_pick_idx;
    logic               w_pick_found;
    logic               w_win_router;
    logic [NUM_REQ-1:0] w_win_oh;
    logic [SEL_W-1:0]   w_win_idx;
    logic [SEL_W-1:0]   w_ptr_nxt;
    logic [LEN_W-1:0]   w_len_sel;
    logic [LEN_W-1:0]   w_len_lat;
    logic               w_beat;
    logic               w_end;

    rr_pick #(.N(NUM_REQ), .IW(SEL_W)) u_pick (
        .i_req   (I_Req),
        .i_ptr   (r_ptr),
        .o_oh    (w_pick_oh),
        .o_idx   (w_pick_idx),
        .o_found (w_pick_found)
    );

`ifdef DMEM_ARB_ROUTER_PRIO_EN
    assign w_win_router = I_Req[0];
`else
    assign w_win_router = 1'b0;
`endif

    assign w_win_oh  = w_win_router ? NUM_REQ'(1) : w_pick_oh;
    assign w_win_idx = w_win_router ? '0 : w_pick_idx;
    // Router-priority grants leave the round-robin pointer where it was.
    assign w_ptr_nxt = w_win_router ? r_ptr :
                       (w_pick_idx == SEL_W'(NUM_REQ - 1)) ? '0 : w_pick_idx + 1'b1;

    always_comb begin
        w_len_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win_oh[i]) w_len_sel = I_Len[i*LEN_W +: LEN_W];
        end
    end

    assign w_len_lat = (w_len_sel == '0) ? LEN_W'(1) : w_len_sel;
    assign w_beat    = O_Valid & I_Mem_Ready;
    // Release from anyone but the owner is masked off by the one-hot grant.
    assign w_end     = (w_beat && (r_cnt == r_len - 1'b1)) || (|(I_Rls & r_grant));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ARB_IDLE;
            r_ptr   <= '0;
            r_sel   <= '0;
            r_grant <= '0;
            r_cnt   <= '0;
            r_len   <= '0;
        end else begin
            case (r_state)
                ARB_IDLE, ARB_TURN: begin
                    if (w_pick_found) begin
                        r_state <= ARB_BURST;
                        r_grant <= w_win_oh;
                        r_sel   <= w_win_idx;
                        r_len   <= w_len_lat;
                        r_cnt   <= '0;
                        r_ptr   <= w_ptr_nxt;
                    end else begin
                        r_state <= ARB_IDLE;
                        r_grant <= '0;
                    end
                end
                ARB_BURST: begin
                    if (w_beat) r_cnt <= r_cnt + 1'b1;
                    if (w_end) begin
                        r_state <= ARB_TURN;
                        r_grant <= '0;
                    end
                end
                default: begin
                    r_state <= ARB_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign O_Grant = r_grant;
    assign O_Sel   = r_sel;
    assign O_Valid = (r_state == ARB_BURST);
    assign O_Last  = O_Valid & (r_cnt == r_len - 1'b1);
    assign O_Busy  = (r_state != ARB_IDLE);

endmodule
